pwm_multiphase: RTL and testbench

//   N-phase PWM gate driver for interleaved switching-converter models (multi-phase buck).

---
 rtl/pwm_multiphase.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_pwm_multiphase.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multiphase.sv
// ---------------------------------------------------------------------------
// pwm_multiphase
//   N-phase complementary PWM gate driver for interleaved converter models.
//   One free-running counter defines the period. Each phase compares a
//   phase-shifted copy of that count against the duty setting. The phases are
//   spaced evenly over the period. Every phase has its own dead-time counter,
//   so the high-side and low-side gates of a phase are never on together.
//
//   New period/duty/dead settings arrive over a load/ready handshake. They are
//   first held in shadow registers while the phase offsets are computed. They
//   are then promoted to the active set only at a period boundary, or at once
//   while the block is disabled. This means a running period is never cut
//   short.
//
// Parameters
//   N_PH        phase count, power of two, 1..16
//   CNT_W       width of the period/duty counter
//   DT_W        width of the dead-time counter
//   RST_PERIOD  period in effect after reset (>= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         run enable; low forces all gates off and holds the counter at 0
//   period     requested period in cycles (values below 2 become 2)
//   duty       requested high time in cycles
//   dead       requested dead-time in cycles
//   load       load request, taken only while ready is high
//   ready      high while no load is pending
//   load_ack   one-cycle pulse when the loaded settings become active
//   sync       one-cycle pulse aligned with the start of phase 0
//   gate_hi    high-side gate per phase
//   gate_lo    low-side gate per phase
//
// All outputs are registered. Gate, sync and load_ack outputs therefore show
// the state of the counter cycle before the one they appear in.
// ---------------------------------------------------------------------------
module pwm_multiphase #(
    parameter int N_PH       = 2,
    parameter int CNT_W      = 16,
    parameter int DT_W       = 8,
    parameter int RST_PERIOD = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  duty,
    input  logic [DT_W-1:0]   dead,
    input  logic              load,
    output logic              ready,
    output logic              load_ack,
    output logic              sync,
    output logic [N_PH-1:0]   gate_hi,
    output logic [N_PH-1:0]   gate_lo
);

    localparam int LOG2  = (N_PH > 1) ? $clog2(N_PH) : 0;
    localparam int IDX_W = (N_PH > 1) ? $clog2(N_PH) : 1;
    // The accumulator reaches (N_PH-1)*period, so it needs LOG2 extra bits.
    localparam int ACC_W = CNT_W + LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    // Offset of phase k that is in effect straight out of reset.
    function automatic logic [CNT_W-1:0] rst_offset(input int k);
        longint unsigned prod;
        prod = longint'(k) * longint'(RST_PERIOD);
        return CNT_W'(prod >> LOG2);
    endfunction

    // Active settings
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] duty_r;
    logic [DT_W-1:0]  dead_r;
    logic [CNT_W-1:0] offset_r     [N_PH];

    // Shadow settings that wait for a period boundary
    logic [CNT_W-1:0] shd_period_r;
    logic [CNT_W-1:0] shd_duty_r;
    logic [DT_W-1:0]  shd_dead_r;
    logic [CNT_W-1:0] shd_offset_r [N_PH];

    // Load FSM and offset computation
    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic [IDX_W-1:0] calc_idx_r;
    logic             ready_r;
    logic             load_ack_r;

    // Counter and per-phase state
    logic [CNT_W-1:0] cnt_r;
    logic             sync_r;
    logic [N_PH-1:0]  raw_prev_r;
    logic [DT_W-1:0]  dt_r         [N_PH];
    logic [N_PH-1:0]  gate_hi_r;
    logic [N_PH-1:0]  gate_lo_r;

    // Combinational helpers
    logic             wrap_s;
    logic             apply_s;
    logic [CNT_W-1:0] period_clamp_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [CNT_W-1:0] phase_s      [N_PH];
    logic [N_PH-1:0]  raw_s;
    logic [N_PH-1:0]  change_s;
    logic [DT_W-1:0]  dt_eff_s     [N_PH];

    // Period boundary, shadow promotion condition, load-side arithmetic.
    always_comb begin
        wrap_s     = en && (cnt_r == (period_r - CNT_W'(1)));
        apply_s    = (state_r == ST_ARMED) && (wrap_s || !en);
        acc_next_s = acc_r + ACC_W'(shd_period_r);
        if (period < CNT_W'(2)) begin
            period_clamp_s = CNT_W'(2);
        end else begin
            period_clamp_s = period;
        end
    end

    // Per-phase position within the period, raw PWM level and edge detect.
    always_comb begin
        phase_s  = '{default: '0};
        dt_eff_s = '{default: '0};
        raw_s    = '0;
        change_s = '0;
        for (int k = 0; k < N_PH; k++) begin
            // The count is always below period_r, and so is the offset.
            // The wrapped subtraction therefore stays within CNT_W.
            if (cnt_r >= offset_r[k]) begin
                phase_s[k] = cnt_r - offset_r[k];
            end else begin
                phase_s[k] = period_r - (offset_r[k] - cnt_r);
            end
            raw_s[k]    = en && (phase_s[k] < duty_r);
            change_s[k] = raw_s[k] ^ raw_prev_r[k];
            // Promoting new settings discards any dead-time still running.
            if (apply_s) begin
                dt_eff_s[k] = DT_W'(0);
            end else begin
                dt_eff_s[k] = dt_r[k];
            end
        end
    end

    // Main period counter: counts 0..period_r-1 while enabled, else held at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CNT_W'(0);
        end else if (!en || wrap_s) begin
            cnt_r <= CNT_W'(0);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Start-of-period marker, registered like the gates so it lines up with phase 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= 1'b0;
        end else begin
            sync_r <= en && (cnt_r == CNT_W'(0));
        end
    end

    // Load handshake FSM: capture, compute offsets, wait for the boundary, promote.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b1;
            load_ack_r   <= 1'b0;
            acc_r        <= ACC_W'(0);
            calc_idx_r   <= IDX_W'(0);
            period_r     <= CNT_W'(RST_PERIOD);
            duty_r       <= CNT_W'(0);
            dead_r       <= DT_W'(0);
            shd_period_r <= CNT_W'(RST_PERIOD);
            shd_duty_r   <= CNT_W'(0);
            shd_dead_r   <= DT_W'(0);
            for (int k = 0; k < N_PH; k++) begin
                offset_r[k]     <= rst_offset(k);
                shd_offset_r[k] <= rst_offset(k);
            end
        end else begin
            load_ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        shd_period_r    <= period_clamp_s;
                        shd_duty_r      <= duty;
                        shd_dead_r      <= dead;
                        shd_offset_r[0] <= CNT_W'(0);
                        acc_r           <= ACC_W'(0);
                        calc_idx_r      <= IDX_W'(1);
                        ready_r         <= 1'b0;
                        // A single phase has no offsets to compute.
                        state_r         <= (N_PH > 1) ? ST_CALC : ST_ARMED;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_CALC: begin
                    // Offset k is (k*period) >> log2(N_PH). It is built by
                    // repeated addition, so no multiplier is needed.
                    acc_r                    <= acc_next_s;
                    shd_offset_r[calc_idx_r] <= CNT_W'(acc_next_s >> LOG2);
                    if (calc_idx_r == IDX_W'(N_PH - 1)) begin
                        state_r <= ST_ARMED;
                    end else begin
                        calc_idx_r <= calc_idx_r + IDX_W'(1);
                    end
                end
                ST_ARMED: begin
                    if (apply_s) begin
                        period_r   <= shd_period_r;
                        duty_r     <= shd_duty_r;
                        dead_r     <= shd_dead_r;
                        for (int k = 0; k < N_PH; k++) begin
                            offset_r[k] <= shd_offset_r[k];
                        end
                        load_ack_r <= 1'b1;
                        ready_r    <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else begin
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Gate drivers: follow the raw level, with both gates forced off for
    // dead_r cycles after every raw edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_hi_r  <= '0;
            gate_lo_r  <= '0;
            raw_prev_r <= '0;
            for (int k = 0; k < N_PH; k++) begin
                dt_r[k] <= DT_W'(0);
            end
        end else begin
            for (int k = 0; k < N_PH; k++) begin
                raw_prev_r[k] <= raw_s[k];
                if (!en) begin
                    gate_hi_r[k] <= 1'b0;
                    gate_lo_r[k] <= 1'b0;
                    dt_r[k]      <= DT_W'(0);
                end else if (change_s[k] && (dead_r != DT_W'(0))) begin
                    // An edge (re)starts the dead-time; both gates go off next cycle.
                    gate_hi_r[k] <= 1'b0;
                    gate_lo_r[k] <= 1'b0;
                    dt_r[k]      <= dead_r;
                end else if (!change_s[k] && (dt_eff_s[k] > DT_W'(1))) begin
                    gate_hi_r[k] <= 1'b0;
                    gate_lo_r[k] <= 1'b0;
                    dt_r[k]      <= dt_eff_s[k] - DT_W'(1);
                end else begin
                    gate_hi_r[k] <= raw_s[k];
                    gate_lo_r[k] <= ~raw_s[k];
                    dt_r[k]      <= DT_W'(0);
                end
            end
        end
    end

    assign ready    = ready_r;
    assign load_ack = load_ack_r;
    assign sync     = sync_r;
    assign gate_hi  = gate_hi_r;
    assign gate_lo  = gate_lo_r;

endmodule

// File: tb/tb_pwm_multiphase.sv
// ---------------------------------------------------------------------------
// tb_pwm_multiphase
//   Directed bench for pwm_multiphase. It uses a 2-phase instance and a
//   4-phase instance that share clock, reset and the setting inputs.
//   Expected gate sequences are written out by hand per period. Index s
//   counts samples from the sync pulse. Sample s shows the counter cycle
//   cnt = s, because every output is registered.
// ---------------------------------------------------------------------------
module tb_pwm_multiphase;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] period_i = 16'd0;
    logic [15:0] duty_i   = 16'd0;
    logic [7:0]  dead_i   = 8'd0;

    logic        en2 = 1'b0, load2 = 1'b0;
    logic        ready2, ack2, sync2;
    logic [1:0]  hi2, lo2;

    logic        en4 = 1'b0, load4 = 1'b0;
    logic        ready4, ack4, sync4;
    logic [3:0]  hi4, lo4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_multiphase #(.N_PH(2), .CNT_W(16), .DT_W(8), .RST_PERIOD(100)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .period(period_i), .duty(duty_i),
        .dead(dead_i), .load(load2), .ready(ready2), .load_ack(ack2),
        .sync(sync2), .gate_hi(hi2), .gate_lo(lo2)
    );

    pwm_multiphase #(.N_PH(4), .CNT_W(16), .DT_W(8), .RST_PERIOD(100)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .period(period_i), .duty(duty_i),
        .dead(dead_i), .load(load4), .ready(ready4), .load_ack(ack4),
        .sync(sync4), .gate_hi(hi4), .gate_lo(lo4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input bit four, input logic v);
        if (four) load4 = v;
        else      load2 = v;
    endtask

    task automatic wait_sync(input bit four);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if ((four ? sync4 : sync2) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("sync_wait", 32'(ok), 32'd1);
    endtask

    task automatic do_load(input bit four, input logic [15:0] p, input logic [15:0] d,
                           input logic [7:0] dd);
        bit ok;
        ok = 1'b0;
        period_i = p; duty_i = d; dead_i = dd;
        set_load(four, 1'b1);
        tick();
        set_load(four, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if ((four ? ack4 : ack2) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check_eq("load_ack_wait", 32'(ok), 32'd1);
    endtask

    function automatic logic [39:0] pack2(input logic [0:9] p0, input logic [0:9] p1);
        logic [39:0] r;
        r = 40'd0;
        for (int s = 0; s < 10; s++) begin
            r[s*4]   = p0[s];
            r[s*4+1] = p1[s];
        end
        return r;
    endfunction

    function automatic logic [39:0] pack4(input logic [0:9] p0, input logic [0:9] p1,
                                          input logic [0:9] p2, input logic [0:9] p3);
        logic [39:0] r;
        r = 40'd0;
        for (int s = 0; s < 10; s++) begin
            r[s*4]   = p0[s];
            r[s*4+1] = p1[s];
            r[s*4+2] = p2[s];
            r[s*4+3] = p3[s];
        end
        return r;
    endfunction

    // Check one 10-cycle period starting at the next sync pulse. Optionally a
    // load is issued after sample load_s, and load_ack is expected at sample ack_s.
    task automatic check_seq(input string tag, input bit four,
                             input logic [39:0] hs, input logic [39:0] ls,
                             input int load_s, input logic [15:0] lp,
                             input logic [15:0] ld, input logic [7:0] ldd,
                             input int ack_s);
        logic [31:0] oh, ol, eh, el;
        bit          exp_ready;
        wait_sync(four);
        for (int s = 0; s < 10; s++) begin
            if (s > 0) tick();
            set_load(four, 1'b0);
            oh = four ? 32'(hi4) : 32'(hi2);
            ol = four ? 32'(lo4) : 32'(lo2);
            eh = four ? 32'(hs[s*4 +: 4]) : 32'(hs[s*4 +: 2]);
            el = four ? 32'(ls[s*4 +: 4]) : 32'(ls[s*4 +: 2]);
            exp_ready = !((load_s >= 0) && (s > load_s) && (s < ack_s));
            check_eq($sformatf("%s_hi_s%0d", tag, s), oh, eh);
            check_eq($sformatf("%s_lo_s%0d", tag, s), ol, el);
            check_eq($sformatf("%s_overlap_s%0d", tag, s), oh & ol, 32'd0);
            check_eq($sformatf("%s_sync_s%0d", tag, s),
                     32'(four ? sync4 : sync2), 32'(s == 0));
            check_eq($sformatf("%s_ack_s%0d", tag, s),
                     32'(four ? ack4 : ack2), 32'(s == ack_s));
            check_eq($sformatf("%s_ready_s%0d", tag, s),
                     32'(four ? ready4 : ready2), 32'(exp_ready));
            if (s == load_s) begin
                period_i = lp; duty_i = ld; dead_i = ldd;
                set_load(four, 1'b1);
            end
        end
    endtask

    logic [39:0] t1_hi, t1_lo, d3_hi, d3_lo, all_hi, all_lo;
    logic [39:0] t2a_hi, t2a_lo, t2s_hi, t2s_lo, t5_hi, t5_lo;
    int          acks, first_sync, second_sync;

    initial begin
        t1_hi  = pack2(10'b1111100000, 10'b0000011111);
        t1_lo  = pack2(10'b0000011111, 10'b1111100000);
        d3_hi  = pack2(10'b1110000000, 10'b0000011100);
        d3_lo  = pack2(10'b0001111111, 10'b1111100011);
        all_hi = pack2(10'b1111111111, 10'b1111111111);
        all_lo = pack2(10'b0000000000, 10'b0000000000);
        // dead=2 directly after a duty=0 period: phase 1 sees no edge at cnt 0
        t2a_hi = pack2(10'b0011100000, 10'b0000000111);
        t2a_lo = pack2(10'b0000000111, 10'b1111100000);
        t2s_hi = pack2(10'b0011100000, 10'b0000000111);
        t2s_lo = pack2(10'b0000000111, 10'b0011100000);
        // 4 phases, period 10: offsets 0/2/5/7, duty 5
        t5_hi  = pack4(10'b1111100000, 10'b0011111000, 10'b0000011111, 10'b1100000111);
        t5_lo  = ~t5_hi;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_hi2", 32'(hi2), 32'd0);
        check_eq("rst_lo2", 32'(lo2), 32'd0);
        check_eq("rst_sync2", 32'(sync2), 32'd0);
        check_eq("rst_ack2", 32'(ack2), 32'd0);
        check_eq("rst_ready2", 32'(ready2), 32'd1);
        check_eq("rst_ready4", 32'(ready4), 32'd1);
        rst = 1'b1;
        tick(); tick();
        check_eq("dis_hi2", 32'(hi2), 32'd0);
        check_eq("dis_lo2", 32'(lo2), 32'd0);

        // T1: period 10, duty 5, no dead-time
        do_load(1'b0, 16'd10, 16'd5, 8'd0);
        en2 = 1'b1;
        check_seq("t1a", 1'b0, t1_hi, t1_lo, -1, 16'd0, 16'd0, 8'd0, -1);
        check_seq("t1b", 1'b0, t1_hi, t1_lo, -1, 16'd0, 16'd0, 8'd0, -1);

        // T3: duty 3 loaded at cnt 4 applies only at the next period
        check_seq("t3a", 1'b0, t1_hi, t1_lo, 3, 16'd10, 16'd3, 8'd0, 9);
        check_seq("t3b", 1'b0, d3_hi, d3_lo, -1, 16'd0, 16'd0, 8'd0, -1);

        // T4: duty beyond period = 100 %, then duty 0 = 0 %
        check_seq("t4a", 1'b0, d3_hi, d3_lo, 3, 16'd10, 16'd12, 8'd0, 9);
        check_seq("t4b", 1'b0, all_hi, all_lo, 3, 16'd10, 16'd0, 8'd0, 9);
        check_seq("t4c", 1'b0, all_lo, all_hi, -1, 16'd0, 16'd0, 8'd0, -1);

        // T2: dead-time 2
        check_seq("t2a", 1'b0, all_lo, all_hi, 3, 16'd10, 16'd5, 8'd2, 9);
        check_seq("t2b", 1'b0, t2a_hi, t2a_lo, -1, 16'd0, 16'd0, 8'd0, -1);
        check_seq("t2c", 1'b0, t2s_hi, t2s_lo, -1, 16'd0, 16'd0, 8'd0, -1);

        // T6b: drop en while phase 0 is high, then re-enable
        wait_sync(1'b0);
        tick(); tick(); tick();
        check_eq("endrop_pre_hi", 32'(hi2), 32'b01);
        en2 = 1'b0;
        tick();
        check_eq("endrop_hi", 32'(hi2), 32'd0);
        check_eq("endrop_lo", 32'(lo2), 32'd0);
        tick(); tick();
        check_eq("endis_sync", 32'(sync2), 32'd0);
        en2 = 1'b1;
        tick();
        check_eq("enrise_sync", 32'(sync2), 32'd1);
        check_eq("enrise_hi_a", 32'(hi2), 32'b00);
        check_eq("enrise_lo_a", 32'(lo2), 32'b10);
        tick();
        check_eq("enrise_hi_b", 32'(hi2), 32'b00);
        tick();
        check_eq("enrise_hi_c", 32'(hi2), 32'b01);
        check_eq("enrise_lo_c", 32'(lo2), 32'b10);

        // T5: four phases
        do_load(1'b1, 16'd10, 16'd5, 8'd0);
        en4 = 1'b1;
        check_seq("t5", 1'b1, t5_hi, t5_lo, -1, 16'd0, 16'd0, 8'd0, -1);
        // period 1 is clamped to 2; a second load while busy is ignored
        period_i = 16'd1; duty_i = 16'd1; dead_i = 8'd0;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        check_eq("t5_busy_ready", 32'(ready4), 32'd0);
        period_i = 16'd10; duty_i = 16'd5;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            if (ack4 === 1'b1) acks++;
            tick();
        end
        check_eq("t5_ack_count", 32'(acks), 32'd1);
        wait_sync(1'b1);
        check_eq("t5_p2_hi_s0", 32'(hi4), 32'b0011);
        check_eq("t5_p2_lo_s0", 32'(lo4), 32'b1100);
        tick();
        check_eq("t5_p2_sync_s1", 32'(sync4), 32'd0);
        check_eq("t5_p2_hi_s1", 32'(hi4), 32'b1100);
        tick();
        check_eq("t5_p2_sync_s2", 32'(sync4), 32'd1);
        check_eq("t5_p2_hi_s2", 32'(hi4), 32'b0011);

        // T6a: reset while a load is armed
        wait_sync(1'b0);
        period_i = 16'd10; duty_i = 16'd7; dead_i = 8'd2;
        load2 = 1'b1;
        tick();
        load2 = 1'b0;
        check_eq("t6_ready_busy", 32'(ready2), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("t6_rst_hi", 32'(hi2), 32'd0);
        check_eq("t6_rst_lo", 32'(lo2), 32'd0);
        check_eq("t6_rst_sync", 32'(sync2), 32'd0);
        check_eq("t6_rst_ack", 32'(ack2), 32'd0);
        check_eq("t6_rst_ready", 32'(ready2), 32'd1);
        check_eq("t6_rst_hi4", 32'(hi4), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        acks = 0; first_sync = -1; second_sync = -1;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (ack2 === 1'b1) acks++;
            if (sync2 === 1'b1) begin
                if (first_sync < 0) first_sync = i;
                else if (second_sync < 0) second_sync = i;
            end
        end
        check_eq("t6_no_ack", 32'(acks), 32'd0);
        check_eq("t6_period", 32'(second_sync - first_sync), 32'd100);
        check_eq("t6_duty0_hi", 32'(hi2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
